// File: rtl/fir_out_decimator.sv
// Block-average decimator for the FIR output stream.
// Rounds half toward +inf and saturates to an OUT_W-bit signed word.
module fir_out_decimator #(
  parameter int DATA_W   = 16,
  parameter int LOG2_DEC = 2,
  parameter int OUT_W    = 8,
  localparam int PH_W    = (LOG2_DEC > 0) ? LOG2_DEC : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     clear,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_sat,
  output logic                     sat_sticky,
  output logic [PH_W-1:0]          phase
);

  localparam int ACC_W = DATA_W + LOG2_DEC;
  localparam int S     = LOG2_DEC + DATA_W - OUT_W;
  localparam int N     = 1 << LOG2_DEC;

  // One extra bit so the rounding offset cannot wrap a full-scale sum.
  localparam logic signed [ACC_W:0] RND   = (ACC_W+1)'((1 << S) >> 1);
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] MIN_V = -MAX_V - 1;
  localparam logic [PH_W-1:0]       LAST  = PH_W'(N - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   r_full;
  logic signed [OUT_W-1:0] r_clamp;
  logic                    r_sat;
  logic                    take;
  logic                    final_s;

  assign take    = in_valid && !clear;
  assign final_s = take && (phase == LAST);

  always_comb begin
    sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(in_data);
    r_full  = (sum + RND) >>> S;
    r_clamp = r_full[OUT_W-1:0];
    r_sat   = 1'b0;
    if (r_full > MAX_V) begin
      r_clamp = MAX_V[OUT_W-1:0];
      r_sat   = 1'b1;
    end else if (r_full < MIN_V) begin
      r_clamp = MIN_V[OUT_W-1:0];
      r_sat   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      phase      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
      sat_sticky <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      phase      <= '0;
      out_valid  <= 1'b0;
      sat_sticky <= 1'b0;
    end else if (final_s) begin
      acc        <= '0;
      phase      <= '0;
      out_valid  <= 1'b1;
      out_data   <= r_clamp;
      out_sat    <= r_sat;
      sat_sticky <= sat_sticky | r_sat;
    end else if (take) begin
      acc       <= sum[ACC_W-1:0];
      phase     <= phase + 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator at default parameters.
// Table of 4-sample blocks plus gap, clear and reset sequences.
module tb_fir_out_decimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        clear = 1'b0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        sat_sticky;
  logic [1:0]  phase;

  int tests = 0;
  int fails = 0;

  fir_out_decimator #(
    .DATA_W(16), .LOG2_DEC(2), .OUT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data),
    .clear(clear),
    .out_valid(out_valid), .out_data(out_data),
    .out_sat(out_sat), .sat_sticky(sat_sticky),
    .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d [4];
    logic [7:0]  exp_data;
    logic        exp_sat;
    logic        exp_sticky;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{'{16'h0100, 16'h0100, 16'h0100, 16'h0100}, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{'{16'h0100, 16'h0200, 16'hFF00, 16'h0000}, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{'{16'hFF80, 16'hFF80, 16'hFF80, 16'hFF80}, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{'{16'hFE00, 16'hFE00, 16'hFE00, 16'hFE00}, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{'{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{'{16'h0000, 16'h0000, 16'h0000, 16'h0000}, 8'h00, 1'b0, 1'b1};
    vecs[6] = '{'{16'h8000, 16'h8000, 16'h8000, 16'h8000}, 8'h80, 1'b0, 1'b1};

    // Reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_sat", 32'(out_sat), 32'h0);
    check("rst_sticky", 32'(sat_sticky), 32'h0);
    check("rst_phase", 32'(phase), 32'h0);

    // Table blocks, back-to-back samples
    foreach (vecs[i]) begin
      for (int k = 0; k < 4; k++) begin
        send(vecs[i].d[k]);
        if (k < 3) begin
          check($sformatf("v%0d_nopulse%0d", i, k), 32'(out_valid), 32'h0);
          check($sformatf("v%0d_phase%0d", i, k), 32'(phase), 32'(k + 1));
        end
      end
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'h1);
      check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_sat", i), 32'(out_sat), 32'(vecs[i].exp_sat));
      check($sformatf("v%0d_sticky", i), 32'(sat_sticky), 32'(vecs[i].exp_sticky));
      check($sformatf("v%0d_phase0", i), 32'(phase), 32'h0);
      tick();
      check($sformatf("v%0d_single", i), 32'(out_valid), 32'h0);
      check($sformatf("v%0d_hold", i), 32'(out_data), 32'(vecs[i].exp_data));
    end

    // Gapped input: gaps of 0, 3, 1 idle cycles
    send(16'hFC00);
    check("gap_ph1", 32'(phase), 32'h1);
    send(16'hFC00);
    for (int g = 0; g < 3; g++) begin
      check("gap_ph2", 32'(phase), 32'h2);
      check("gap_nov2", 32'(out_valid), 32'h0);
      tick();
    end
    send(16'hFC00);
    check("gap_ph3", 32'(phase), 32'h3);
    tick();
    check("gap_ph3b", 32'(phase), 32'h3);
    check("gap_nov3", 32'(out_valid), 32'h0);
    send(16'hFC00);
    check("gap_valid", 32'(out_valid), 32'h1);
    check("gap_data", 32'(out_data), 32'hFC);
    tick();
    check("gap_single", 32'(out_valid), 32'h0);

    // Clear with a valid sample mid-block; sticky was set earlier
    check("clr_pre_sticky", 32'(sat_sticky), 32'h1);
    send(16'h7FFF);
    send(16'h7FFF);
    clear = 1'b1;
    send(16'h7FFF);
    clear = 1'b0;
    check("clr_sticky", 32'(sat_sticky), 32'h0);
    check("clr_phase", 32'(phase), 32'h0);
    check("clr_nov", 32'(out_valid), 32'h0);
    check("clr_hold", 32'(out_data), 32'hFC);
    for (int k = 0; k < 4; k++) send(16'h0400);
    check("clr_valid", 32'(out_valid), 32'h1);
    check("clr_data", 32'(out_data), 32'h04);
    check("clr_sat", 32'(out_sat), 32'h0);
    check("clr_sticky2", 32'(sat_sticky), 32'h0);

    // Clear together with the final sample: no pulse, sample dropped
    for (int k = 0; k < 3; k++) send(16'h7FFF);
    clear = 1'b1;
    send(16'h7FFF);
    clear = 1'b0;
    check("clrfin_nov", 32'(out_valid), 32'h0);
    check("clrfin_hold", 32'(out_data), 32'h04);
    check("clrfin_sticky", 32'(sat_sticky), 32'h0);
    check("clrfin_phase", 32'(phase), 32'h0);

    // Asynchronous reset mid-block
    for (int k = 0; k < 3; k++) send(16'h0100);
    check("arst_pre_phase", 32'(phase), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_data", 32'(out_data), 32'h00);
    check("arst_phase", 32'(phase), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      send(16'h0100);
      if (k < 3) check("arst_nopulse", 32'(out_valid), 32'h0);
    end
    check("arst_valid2", 32'(out_valid), 32'h1);
    check("arst_data2", 32'(out_data), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_out_decimator.md
# fir_out_decimator

Downstream stage of the 8-tap FIR core. It accepts the 16-bit signed filter output one sample per valid cycle and averages blocks of 2^LOG2_DEC samples. The average is rounded and saturated to an OUT_W-bit signed word, which drives the 8-bit dedicated output pins at a reduced rate with a one-cycle valid strobe.

## Interface
- DATA_W, 16, width of the signed input sample (FIR output word)
- LOG2_DEC, 2, log2 of the decimation factor N; legal range 0..4
- OUT_W, 8, width of the signed output word; must satisfy OUT_W <= DATA_W
- clk  input  1  single clock, rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  in_data holds a sample to accept this cycle
- in_data  input  DATA_W  signed two's-complement FIR output sample
- clear  input  1  synchronous flush of the partial block and the sticky flag
- out_valid  output  1  one-cycle pulse; out_data is updated on this cycle
- out_data  output  OUT_W  signed decimated result, held between pulses
- out_sat  output  1  the current out_data was saturated; updates with out_valid
- sat_sticky  output  1  set on any saturation; cleared only by clear or reset
- phase  output  LOG2_DEC (min 1)  number of samples accepted in the current block

## Operation
- Accumulator acc: signed, DATA_W+LOG2_DEC bits, so N full-scale samples cannot overflow.
- Counter phase runs 0..N-1 and increments on each accepted sample (in_valid=1, clear=0).
- Non-final sample (phase < N-1):
  - acc <= acc + in_data (sign-extended).
  - phase increments.
- Final sample (phase == N-1):
  - sum = acc + in_data.
  - S = LOG2_DEC + DATA_W - OUT_W.
  - If S > 0: r = (sum + 2^(S-1)) >>> S, an arithmetic shift that rounds half toward +inf. If S = 0: r = sum.
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_data <= clamped value. out_sat <= 1 if clamping changed r, else 0.
  - sat_sticky is set to 1 if clamping changed r.
  - out_valid <= 1. acc <= 0. phase <= 0.
- Any cycle with no final-sample acceptance: out_valid <= 0. out_data and out_sat hold.
- LOG2_DEC = 0: every accepted sample is final. This gives a pure rounding and saturation stage with out_valid following in_valid by one cycle.
- clear = 1:
  - acc <= 0, phase <= 0, sat_sticky <= 0, out_valid <= 0.
  - in_valid on the same cycle is discarded.
  - out_data and out_sat hold their last value.
- in_valid = 0: acc and phase hold. Gaps of any length are allowed within a block.

## Timing
- Reset (rst_n low, asynchronous): acc = 0, phase = 0, out_valid = 0, out_data = 0, out_sat = 0, sat_sticky = 0. Reset applies immediately, even mid-block; the partial block is lost.
- Latency: out_valid and the new out_data appear on the rising edge that accepts the Nth sample, i.e. they are visible in the cycle after the Nth in_valid.
- Throughput: one input per cycle sustained; one output every N accepted samples. There is no backpressure; the consumer must sample out_data while out_valid = 1, or later, since it holds.
- clear and the final sample in the same cycle: clear wins, no out_valid pulse is produced, and the sample is dropped.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
Default parameters: N = 4, S = 10.

- **Reset:** hold rst_n = 0 for 3 cycles, then release -> out_data = 0x00, out_valid = 0, sat_sticky = 0, phase = 0.
- **Rounding and latency:** 4 back-to-back samples of 0x0100 -> sum = 1024, r = (1024+512)>>>10 = 1. out_data = 0x01 with a single out_valid pulse in the cycle after the 4th sample; out_sat = 0.
- **Positive saturation:** 4 samples of 0x7FFF -> r = 128, so out_data = 0x7F, out_sat = 1, sat_sticky = 1. Then 4 samples of 0x0000 -> out_data = 0x00, out_sat = 0, sat_sticky stays 1.
- **Negative full scale:** 4 samples of 0x8000 -> r = -128, so out_data = 0x80 and out_sat = 0.
- **Gapped input:** 4 samples of 0xFC00 (-1024) with 0, 3, 1 idle cycles between them -> exactly one pulse, one cycle after the 4th; r = (-4096+512)>>>10 = -4, so out_data = 0xFC. phase reads 1, 2, 3 during the gaps.
- **Clear and reset mid-block:**
  - Accept 2 samples of 0x7FFF, pulse clear together with a 3rd valid sample, then send 4 samples of 0x0400 -> one pulse with out_data = 0x04, and sat_sticky = 0.
  - Assert rst_n low after 3 samples -> no pulse; all outputs are 0 immediately.
